// File: rtl/alu_op_sequencer.sv
// Multi-cycle 8-bit ALU sequencer. Short ops (ADD/SUB/INC/DEC, reserved,
// divide-by-zero) finish one edge after accept; MUL and DIV/MOD run eight
// single-bit iterations. Results are registered and held until consumed.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHORT | single-edge operation in flight
// ITER  | shift-add multiply or restoring divide, one bit per edge
// DONE  | result presented, waiting for out_ready
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] res_lo,
  output logic [7:0] res_hi,
  output logic [3:0] nzvc,
  output logic       err,
  output logic       busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;
  localparam logic [2:0] OP_DEC = 3'b110;

  typedef enum logic [1:0] {IDLE, SHORT, ITER, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [7:0]  a_q, b_q;
  logic [2:0]  cnt;
  logic [15:0] acc;
  logic [7:0]  rem, quo;

  logic        accept, long_op, last_iter;
  logic [2:0]  bit_idx;
  logic [15:0] acc_nxt;
  logic [8:0]  rem_sh;
  logic        rem_ge;
  logic [7:0]  rem_nxt, quo_nxt;

  logic [7:0]  opnd, opnd_eff;
  logic        is_sub;
  logic [8:0]  sum;
  logic [7:0]  short_lo, short_hi;
  logic [3:0]  short_nzvc;
  logic        short_err;
  logic [7:0]  long_lo, long_hi;
  logic [3:0]  long_nzvc;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  // Only multiply and a real divide need the iterative path.
  assign long_op   = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != 8'd0));
  assign last_iter = (cnt == 3'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = long_op ? ITER : SHORT;
      SHORT:   state_nxt = DONE;
      ITER:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step: multiply walks LSB first, divide walks MSB first.
  always_comb begin
    bit_idx = (op_q == OP_MUL) ? (3'd7 - cnt) : cnt;
    acc_nxt = acc + (b_q[bit_idx] ? ({8'd0, a_q} << bit_idx) : 16'd0);
    rem_sh  = {rem, a_q[bit_idx]};
    rem_ge  = (rem_sh >= {1'b0, b_q});
    rem_nxt = rem_ge ? 8'(rem_sh - {1'b0, b_q}) : rem_sh[7:0];
    quo_nxt = quo;
    quo_nxt[bit_idx] = rem_ge;
  end

  // Single-edge results; INC/DEC reuse the adder with a constant one.
  always_comb begin
    opnd       = ((op_q == OP_INC) || (op_q == OP_DEC)) ? 8'h01 : b_q;
    is_sub     = (op_q == OP_SUB) || (op_q == OP_DEC);
    opnd_eff   = is_sub ? ~opnd : opnd;
    sum        = {1'b0, a_q} + {1'b0, opnd_eff} + {8'd0, is_sub};
    short_lo   = 8'd0;
    short_hi   = 8'd0;
    short_nzvc = 4'b0100;
    short_err  = 1'b1;
    case (op_q)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        short_lo   = sum[7:0];
        short_err  = 1'b0;
        short_nzvc = {sum[7], (sum[7:0] == 8'd0),
                      (a_q[7] == opnd_eff[7]) && (sum[7] != a_q[7]), sum[8]};
      end
      OP_DIV, OP_MOD: short_nzvc = 4'b0110;
      default: ;
    endcase
  end

  // Final-iteration results, built from the step that completes on this edge.
  always_comb begin
    long_lo   = acc_nxt[7:0];
    long_hi   = acc_nxt[15:8];
    long_nzvc = {acc_nxt[15], (acc_nxt == 16'd0), (acc_nxt[15:8] != 8'd0), 1'b0};
    if (op_q == OP_DIV) begin
      long_lo   = quo_nxt;
      long_hi   = rem_nxt;
      long_nzvc = {quo_nxt[7], (quo_nxt == 8'd0), 2'b00};
    end else if (op_q == OP_MOD) begin
      long_lo   = rem_nxt;
      long_hi   = quo_nxt;
      long_nzvc = {rem_nxt[7], (rem_nxt == 8'd0), 2'b00};
    end
  end

  // Operand capture, iteration registers and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= 3'd0;
      a_q    <= 8'd0;
      b_q    <= 8'd0;
      cnt    <= 3'd0;
      acc    <= 16'd0;
      rem    <= 8'd0;
      quo    <= 8'd0;
      res_lo <= 8'd0;
      res_hi <= 8'd0;
      nzvc   <= 4'd0;
      err    <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        cnt  <= 3'd7;
        acc  <= 16'd0;
        rem  <= 8'd0;
        quo  <= 8'd0;
      end
      if (state == ITER) begin
        acc <= acc_nxt;
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt - 3'd1;
      end
      if (state == SHORT) begin
        res_lo <= short_lo;
        res_hi <= short_hi;
        nzvc   <= short_nzvc;
        err    <= short_err;
      end else if ((state == ITER) && last_iter) begin
        res_lo <= long_lo;
        res_hi <= long_hi;
        nzvc   <= long_nzvc;
        err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vectors, randomized ops against an
// arithmetic reference model, backpressure and mid-operation reset.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [2:0] op;
  logic [7:0] a, b, res_lo, res_hi;
  logic [3:0] nzvc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res_lo(res_lo), .res_hi(res_hi), .nzvc(nzvc), .err(err), .busy(busy)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [20:0] exp;
    logic [3:0]  lat;
  } vec_t;

  // Reference result {err, nzvc, res_hi, res_lo} from plain arithmetic.
  function automatic logic [20:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int r, sx, sb, sr, bv, q, m;
    bit sub, v, c;
    logic [7:0] lo, hi;
    logic [3:0] f;
    logic [15:0] p;
    logic e;
    lo = 8'd0; hi = 8'd0; f = 4'd0; e = 1'b0;
    case (o)
      3'd0, 3'd1, 3'd5, 3'd6: begin
        bv  = (o == 3'd5 || o == 3'd6) ? 1 : int'(y);
        sub = (o == 3'd1 || o == 3'd6);
        sx  = (x > 127) ? int'(x) - 256 : int'(x);
        sb  = (bv > 127) ? bv - 256 : bv;
        sr  = sub ? sx - sb : sx + sb;
        v   = (sr > 127) || (sr < -128);
        r   = sub ? int'(x) - bv : int'(x) + bv;
        c   = sub ? (int'(x) >= bv) : (r > 255);
        lo  = r[7:0];
        f   = {lo[7], lo == 8'd0, v, c};
      end
      3'd2: begin
        p  = 16'(x) * 16'(y);
        lo = p[7:0];
        hi = p[15:8];
        f  = {p[15], p == 16'd0, p[15:8] != 8'd0, 1'b0};
      end
      3'd3, 3'd4: begin
        if (y == 8'd0) begin
          e = 1'b1;
          f = 4'b0110;
        end else begin
          q  = int'(x) / int'(y);
          m  = int'(x) % int'(y);
          lo = (o == 3'd3) ? q[7:0] : m[7:0];
          hi = (o == 3'd3) ? m[7:0] : q[7:0];
          f  = {lo[7], lo == 8'd0, 2'b00};
        end
      end
      default: begin
        e = 1'b1;
        f = 4'b0100;
      end
    endcase
    return {e, f, hi, lo};
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [7:0] y);
    return (o == 3'd2 || ((o == 3'd3 || o == 3'd4) && y != 8'd0)) ? 8 : 1;
  endfunction

  // Issue one request, scramble inputs while busy, wait for out_valid.
  // Leaves the DUT in DONE with out_ready low; lat=99 means it never completed.
  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       output int lat, output logic [20:0] obs);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      op = 3'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    obs = {err, nzvc, res_hi, res_lo};
  endtask

  task automatic finish_op();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (res_lo !== 8'd0)    begin errors++; $display("FAIL reset_res_lo got=%h want=00", res_lo); end
    if (res_hi !== 8'd0)    begin errors++; $display("FAIL reset_res_hi got=%h want=00", res_hi); end
    if (nzvc !== 4'd0)      begin errors++; $display("FAIL reset_nzvc got=%b want=0000", nzvc); end
    if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    vec_t vecs [10];
    int lat;
    logic [20:0] obs;
    vecs = '{
      '{3'd0, 8'h7F, 8'h01, {1'b0, 4'b1010, 8'h00, 8'h80}, 4'd1},
      '{3'd1, 8'h05, 8'h05, {1'b0, 4'b0101, 8'h00, 8'h00}, 4'd1},
      '{3'd6, 8'h00, 8'h37, {1'b0, 4'b1000, 8'h00, 8'hFF}, 4'd1},
      '{3'd5, 8'hFF, 8'h9A, {1'b0, 4'b0101, 8'h00, 8'h00}, 4'd1},
      '{3'd2, 8'hFF, 8'hFF, {1'b0, 4'b1010, 8'hFE, 8'h01}, 4'd8},
      '{3'd2, 8'h0F, 8'h11, {1'b0, 4'b0000, 8'h00, 8'hFF}, 4'd8},
      '{3'd3, 8'hC8, 8'h07, {1'b0, 4'b0000, 8'h04, 8'h1C}, 4'd8},
      '{3'd4, 8'hC8, 8'h07, {1'b0, 4'b0000, 8'h1C, 8'h04}, 4'd8},
      '{3'd3, 8'h10, 8'h00, {1'b1, 4'b0110, 8'h00, 8'h00}, 4'd1},
      '{3'd7, 8'h12, 8'h34, {1'b1, 4'b0100, 8'h00, 8'h00}, 4'd1}
    };
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, obs);
      checks += 2;
      if (lat != int'(vecs[i].lat)) begin
        errors++;
        $display("FAIL directed_latency vec=%0d got=%0d want=%0d", i, lat, vecs[i].lat);
      end
      if (obs !== vecs[i].exp) begin
        errors++;
        $display("FAIL directed_result vec=%0d got=%h want=%h", i, obs, vecs[i].exp);
      end
      finish_op();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL directed_release vec=%0d in_ready=%b want=1", i, in_ready); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [20:0] obs, exp;
    logic [2:0] o;
    logic [7:0] x, y;
    for (int k = 0; k < 150; k++) begin
      o = 3'($urandom_range(0, 7));
      x = 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      exp = model(o, x, y);
      do_op(o, x, y, lat, obs);
      checks += 2;
      if (lat != exp_lat(o, y)) begin
        errors++;
        $display("FAIL random_latency op=%0d a=%h b=%h got=%0d want=%0d", o, x, y, lat, exp_lat(o, y));
      end
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_result op=%0d a=%h b=%h got=%h want=%h", o, x, y, obs, exp);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [20:0] obs, exp;
    exp = model(3'd2, 8'hD3, 8'h5B);
    do_op(3'd2, 8'hD3, 8'h5B, lat, obs);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_result got=%h want=%h", obs, exp); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 8'($urandom);
      b = 8'($urandom);
      op = 3'($urandom);
      @(posedge clk);
      #1;
      checks += 3;
      if ({err, nzvc, res_hi, res_lo} !== exp) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got=%h want=%h", k, {err, nzvc, res_hi, res_lo}, exp);
      end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", k, out_valid); end
      if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", k, in_ready); end
    end
    finish_op();
    checks += 2;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    int lat, pulses;
    logic [20:0] obs, exp;
    @(negedge clk);
    op = 3'd3; a = 8'd200; b = 8'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL mid_running E%0d out_valid=%b busy=%b want=0/1", k, out_valid, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks += 2;
    if ({err, nzvc, res_hi, res_lo} !== 21'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h want=0", {err, nzvc, res_hi, res_lo});
    end
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags out_valid=%b busy=%b want=0/0", out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got=%b want=1", in_ready); end
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL mid_reset_no_pulse got=%0d pulses want=0", pulses); end
    exp = model(3'd0, 8'h12, 8'h34);
    do_op(3'd0, 8'h12, 8'h34, lat, obs);
    checks += 2;
    if (lat != 1)     begin errors++; $display("FAIL mid_add_latency got=%0d want=1", lat); end
    if (obs !== exp)  begin errors++; $display("FAIL mid_add_result got=%h want=%h", obs, exp); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
